// File: rtl/rtoy_decode_stage.sv
// rtoy_decode_stage: decodes one instruction beat per cycle into a registered
// bundle for execute. A small scoreboard of older destinations produces
// forwarding selects, and a load followed immediately by a consumer costs
// one bubble.
module rtoy_decode_stage #(
    parameter int FWD_DEPTH = 2,
    parameter int FW        = $clog2(FWD_DEPTH + 1)
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [31:0]   IN_INSTR,
    input  logic [31:0]   IN_PC,
    input  logic          FLUSH,
    output logic          D_VALID,
    input  logic          D_READY,
    output logic [31:0]   D_PC,
    output logic [4:0]    D_OPCODE,
    output logic [4:0]    D_RA,
    output logic [4:0]    D_RB,
    output logic [4:0]    D_RC,
    output logic [31:0]   D_IMM,
    output logic          D_WE,
    output logic          D_MEM_RD,
    output logic          D_MEM_WR,
    output logic          D_BRANCH,
    output logic          D_ILLEGAL,
    output logic [FW-1:0] D_FWD_B,
    output logic [FW-1:0] D_FWD_C,
    output logic [FW-1:0] D_FWD_S
);

    typedef enum logic [4:0] {
        OP_ADDI = 5'd0,  OP_ANDI = 5'd1,  OP_ORI  = 5'd2,  OP_MOVI = 5'd3,
        OP_ADD  = 5'd4,  OP_SUB  = 5'd5,  OP_NEG  = 5'd6,  OP_NOT  = 5'd7,
        OP_AND  = 5'd8,  OP_OR   = 5'd9,  OP_XOR  = 5'd10, OP_LSR  = 5'd11,
        OP_ASR  = 5'd12, OP_SHL  = 5'd13, OP_ROR  = 5'd14, OP_BR   = 5'd15,
        OP_BRL  = 5'd16, OP_J    = 5'd17, OP_JL   = 5'd18, OP_LD   = 5'd19,
        OP_LDR  = 5'd20, OP_ST   = 5'd21, OP_STR  = 5'd22
    } opcode_e;

    // Instruction fields of the incoming beat
    logic [4:0]  in_op;
    logic [4:0]  in_ra;
    logic [4:0]  in_rb;
    logic [4:0]  in_rc;
    logic [31:0] imm_sext17;
    logic [31:0] imm_zext17;
    logic [31:0] imm_sext22;
    logic [31:0] imm_shamt;
    logic [31:0] imm_br;

    assign in_op      = IN_INSTR[31:27];
    assign in_ra      = IN_INSTR[26:22];
    assign in_rb      = IN_INSTR[21:17];
    assign in_rc      = IN_INSTR[16:12];
    assign imm_sext17 = {{15{IN_INSTR[16]}}, IN_INSTR[16:0]};
    assign imm_zext17 = {15'b0, IN_INSTR[16:0]};
    assign imm_sext22 = {{10{IN_INSTR[21]}}, IN_INSTR[21:0]};
    assign imm_shamt  = {27'b0, IN_INSTR[4:0]};
    assign imm_br     = {29'b0, IN_INSTR[2:0]};

    // Decoded control for the incoming beat
    logic        dec_rd_b;
    logic        dec_rd_c;
    logic        dec_rd_s;
    logic        dec_we;
    logic        dec_mem_rd;
    logic        dec_mem_wr;
    logic        dec_branch;
    logic        dec_illegal;
    logic [31:0] dec_imm;

    // Opcode decode: source reads, write enable, class flags and immediate
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a signal unassigned, which would otherwise infer a latch.
        dec_rd_b    = 1'b0;
        dec_rd_c    = 1'b0;
        dec_rd_s    = 1'b0;
        dec_we      = 1'b0;
        dec_mem_rd  = 1'b0;
        dec_mem_wr  = 1'b0;
        dec_branch  = 1'b0;
        dec_illegal = 1'b0;
        dec_imm     = 32'b0;
        case (in_op)
            OP_ADDI: begin
                dec_rd_b = 1'b1;
                dec_we   = 1'b1;
                dec_imm  = imm_sext17;
            end
            OP_ANDI, OP_ORI: begin
                dec_rd_b = 1'b1;
                dec_we   = 1'b1;
                dec_imm  = imm_zext17;
            end
            OP_MOVI: begin
                dec_we  = 1'b1;
                dec_imm = imm_sext17;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                dec_rd_b = 1'b1;
                dec_rd_c = 1'b1;
                dec_we   = 1'b1;
            end
            OP_NEG, OP_NOT: begin
                dec_rd_c = 1'b1;
                dec_we   = 1'b1;
            end
            OP_LSR, OP_ASR, OP_SHL, OP_ROR: begin
                // INSTR[5] picks an immediate shift amount over register rc
                dec_rd_b = 1'b1;
                dec_we   = 1'b1;
                if (IN_INSTR[5]) begin
                    dec_imm = imm_shamt;
                end else begin
                    dec_rd_c = 1'b1;
                end
            end
            OP_BR, OP_BRL: begin
                dec_rd_b   = 1'b1;
                dec_rd_c   = 1'b1;
                dec_branch = 1'b1;
                dec_we     = (in_op == OP_BRL);
                dec_imm    = imm_br;
            end
            OP_J, OP_JL: begin
                dec_branch = 1'b1;
                dec_we     = (in_op == OP_JL);
                dec_imm    = imm_sext22;
            end
            OP_LD: begin
                dec_rd_b   = 1'b1;
                dec_we     = 1'b1;
                dec_mem_rd = 1'b1;
                dec_imm    = imm_sext17;
            end
            OP_LDR: begin
                dec_we     = 1'b1;
                dec_mem_rd = 1'b1;
                dec_imm    = imm_sext22;
            end
            OP_ST: begin
                dec_rd_b   = 1'b1;
                dec_rd_s   = 1'b1;
                dec_mem_wr = 1'b1;
                dec_imm    = imm_sext17;
            end
            OP_STR: begin
                dec_rd_s   = 1'b1;
                dec_mem_wr = 1'b1;
                dec_imm    = imm_sext22;
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
    end

    // Handshake: the D register moves whenever it is empty or being taken
    logic advance;
    logic load_hazard;
    logic stall;
    logic sb_shift;

    assign advance = !D_VALID || D_READY;

    // A load still sitting in D cannot forward to its immediate consumer
    assign load_hazard = D_VALID && D_WE && D_MEM_RD &&
                         ((dec_rd_b && (in_rb == D_RA)) ||
                          (dec_rd_c && (in_rc == D_RA)) ||
                          (dec_rd_s && (in_ra == D_RA)));

    assign stall    = IN_VALID && advance && load_hazard;
    assign IN_READY = (advance && !stall) || FLUSH;

    // Flush kills only D; older producers already in flight stay tracked
    assign sb_shift = advance && !FLUSH;

    // Scoreboard of older destinations; index 0 is the youngest entry
    logic       sb_valid  [FWD_DEPTH];
    logic [4:0] sb_dest   [FWD_DEPTH];
    logic       sb_load   [FWD_DEPTH];
    logic       nxt_valid [FWD_DEPTH];
    logic [4:0] nxt_dest  [FWD_DEPTH];
    logic       nxt_load  [FWD_DEPTH];

    // Next scoreboard: shift the leaving D bundle in on advance, else hold
    always_comb begin
        if (sb_shift) begin
            nxt_valid[0] = D_VALID && D_WE;
            nxt_dest[0]  = D_RA;
            nxt_load[0]  = D_MEM_RD;
        end else begin
            nxt_valid[0] = sb_valid[0];
            nxt_dest[0]  = sb_dest[0];
            nxt_load[0]  = sb_load[0];
        end
        for (int k = 1; k < FWD_DEPTH; k++) begin
            if (sb_shift) begin
                nxt_valid[k] = sb_valid[k-1];
                nxt_dest[k]  = sb_dest[k-1];
                nxt_load[k]  = sb_load[k-1];
            end else begin
                nxt_valid[k] = sb_valid[k];
                nxt_dest[k]  = sb_dest[k];
                nxt_load[k]  = sb_load[k];
            end
        end
    end

    // Forwarding selects, matched against the scoreboard the bundle will see
    // while it sits in D; the youngest matching producer wins.
    logic [FW-1:0] dec_fwd_b;
    logic [FW-1:0] dec_fwd_c;
    logic [FW-1:0] dec_fwd_s;

    // Priority search from oldest to youngest so the youngest match is kept
    always_comb begin
        dec_fwd_b = '0;
        dec_fwd_c = '0;
        dec_fwd_s = '0;
        for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
            if (nxt_valid[k] && dec_rd_b && (nxt_dest[k] == in_rb)) begin
                dec_fwd_b = FW'(k + 1);
            end
            if (nxt_valid[k] && dec_rd_c && (nxt_dest[k] == in_rc)) begin
                dec_fwd_c = FW'(k + 1);
            end
            if (nxt_valid[k] && dec_rd_s && (nxt_dest[k] == in_ra)) begin
                dec_fwd_s = FW'(k + 1);
            end
        end
    end

    // Scoreboard state register
    always_ff @(posedge CLK or negedge RSTN) begin
        // NOTE: the scoreboard is only a few flops and must read as empty
        // straight out of reset, so every entry is reset, not just valid bits.
        if (!RSTN) begin
            for (int k = 0; k < FWD_DEPTH; k++) begin
                sb_valid[k] <= 1'b0;
                sb_dest[k]  <= 5'b0;
                sb_load[k]  <= 1'b0;
            end
        end else begin
            for (int k = 0; k < FWD_DEPTH; k++) begin
                sb_valid[k] <= nxt_valid[k];
                sb_dest[k]  <= nxt_dest[k];
                sb_load[k]  <= nxt_load[k];
            end
        end
    end

    // Output bundle register: flush, then bubble on stall/empty, then load
    always_ff @(posedge CLK or negedge RSTN) begin
        // NOTE: state is written with non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!RSTN) begin
            D_VALID   <= 1'b0;
            D_PC      <= 32'b0;
            D_OPCODE  <= 5'b0;
            D_RA      <= 5'b0;
            D_RB      <= 5'b0;
            D_RC      <= 5'b0;
            D_IMM     <= 32'b0;
            D_WE      <= 1'b0;
            D_MEM_RD  <= 1'b0;
            D_MEM_WR  <= 1'b0;
            D_BRANCH  <= 1'b0;
            D_ILLEGAL <= 1'b0;
            D_FWD_B   <= '0;
            D_FWD_C   <= '0;
            D_FWD_S   <= '0;
        end else if (FLUSH) begin
            D_VALID <= 1'b0;
        end else if (advance) begin
            if (IN_VALID && !stall) begin
                D_VALID   <= 1'b1;
                D_PC      <= IN_PC;
                D_OPCODE  <= in_op;
                D_RA      <= in_ra;
                D_RB      <= in_rb;
                D_RC      <= in_rc;
                D_IMM     <= dec_imm;
                D_WE      <= dec_we;
                D_MEM_RD  <= dec_mem_rd;
                D_MEM_WR  <= dec_mem_wr;
                D_BRANCH  <= dec_branch;
                D_ILLEGAL <= dec_illegal;
                D_FWD_B   <= dec_fwd_b;
                D_FWD_C   <= dec_fwd_c;
                D_FWD_S   <= dec_fwd_s;
            end else begin
                D_VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rtoy_decode_stage.sv
// Directed bench for rtoy_decode_stage: forwarding distances, load-use
// bubble, immediate forms, back-pressure, flush, illegal opcode and reset.
module tb_rtoy_decode_stage;

    localparam int FWD_DEPTH = 2;
    localparam int FW        = 2;

    logic          CLK = 1'b0;
    logic          RSTN;
    logic          IN_VALID;
    logic          IN_READY;
    logic [31:0]   IN_INSTR;
    logic [31:0]   IN_PC;
    logic          FLUSH;
    logic          D_VALID;
    logic          D_READY;
    logic [31:0]   D_PC;
    logic [4:0]    D_OPCODE;
    logic [4:0]    D_RA;
    logic [4:0]    D_RB;
    logic [4:0]    D_RC;
    logic [31:0]   D_IMM;
    logic          D_WE;
    logic          D_MEM_RD;
    logic          D_MEM_WR;
    logic          D_BRANCH;
    logic          D_ILLEGAL;
    logic [FW-1:0] D_FWD_B;
    logic [FW-1:0] D_FWD_C;
    logic [FW-1:0] D_FWD_S;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    rtoy_decode_stage #(.FWD_DEPTH(FWD_DEPTH), .FW(FW)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_INSTR(IN_INSTR),
        .IN_PC(IN_PC), .FLUSH(FLUSH),
        .D_VALID(D_VALID), .D_READY(D_READY), .D_PC(D_PC),
        .D_OPCODE(D_OPCODE), .D_RA(D_RA), .D_RB(D_RB), .D_RC(D_RC),
        .D_IMM(D_IMM), .D_WE(D_WE), .D_MEM_RD(D_MEM_RD), .D_MEM_WR(D_MEM_WR),
        .D_BRANCH(D_BRANCH), .D_ILLEGAL(D_ILLEGAL),
        .D_FWD_B(D_FWD_B), .D_FWD_C(D_FWD_C), .D_FWD_S(D_FWD_S)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] op, input logic [4:0] ra,
                                          input logic [4:0] rb, input logic [4:0] rc);
        return {op, ra, rb, rc, 12'h000};
    endfunction

    function automatic logic [31:0] enc_i(input logic [4:0] op, input logic [4:0] ra,
                                          input logic [4:0] rb, input logic [16:0] imm);
        return {op, ra, rb, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [4:0] op, input logic [4:0] ra,
                                          input logic [21:0] imm);
        return {op, ra, imm};
    endfunction

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
        IN_VALID = 1'b1;
        IN_INSTR = instr;
        IN_PC    = pc;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        IN_VALID = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        RSTN     = 1'b0;
        IN_VALID = 1'b0;
        IN_INSTR = 32'h0;
        IN_PC    = 32'h0;
        FLUSH    = 1'b0;
        D_READY  = 1'b1;

        // Reset state
        #12;
        check("rst_d_valid", D_VALID, 0);
        check("rst_d_imm", D_IMM, 0);
        check("rst_d_pc", D_PC, 0);
        check("rst_fwd_b", D_FWD_B, 0);
        check("rst_in_ready", IN_READY, 1);
        tick();
        RSTN = 1'b1;

        // ADD r3,r1,r2 then SUB r4,r3,r3 back to back
        drive(enc_r(5'd4, 5'd3, 5'd1, 5'd2), 32'h100);
        #1 check("add_in_ready", IN_READY, 1);
        tick();
        check("add_valid", D_VALID, 1);
        check("add_opcode", D_OPCODE, 4);
        check("add_ra", D_RA, 3);
        check("add_we", D_WE, 1);
        check("add_pc", D_PC, 32'h100);
        check("add_fwd_b", D_FWD_B, 0);
        drive(enc_r(5'd5, 5'd4, 5'd3, 5'd3), 32'h104);
        tick();
        check("sub_fwd_b", D_FWD_B, 1);
        check("sub_fwd_c", D_FWD_C, 1);
        check("sub_pc", D_PC, 32'h104);
        idle(1);
        check("gap_valid", D_VALID, 0);
        // AND r7,r4,r3: r4 two back, r3 beyond tracked depth
        drive(enc_r(5'd8, 5'd7, 5'd4, 5'd3), 32'h10C);
        tick();
        check("and_fwd_b_dist2", D_FWD_B, 2);
        check("and_fwd_c_aged_out", D_FWD_C, 0);
        idle(3);

        // LD r5,[r1+4] then ADD r6,r5,r2: one bubble, then forward from 2
        drive(enc_i(5'd19, 5'd5, 5'd1, 17'd4), 32'h200);
        tick();
        check("ld_mem_rd", D_MEM_RD, 1);
        check("ld_imm", D_IMM, 32'h4);
        check("ld_we", D_WE, 1);
        drive(enc_r(5'd4, 5'd6, 5'd5, 5'd2), 32'h204);
        #1 check("lu_stall_in_ready", IN_READY, 0);
        tick();
        check("lu_bubble_valid", D_VALID, 0);
        check("lu_retry_in_ready", IN_READY, 1);
        tick();
        check("lu_add_valid", D_VALID, 1);
        check("lu_add_pc", D_PC, 32'h204);
        check("lu_add_fwd_b", D_FWD_B, 2);
        check("lu_add_fwd_c", D_FWD_C, 0);
        idle(3);

        // Immediate forms
        drive(enc_i(5'd1, 5'd1, 5'd2, 17'h1FFFF), 32'h300);
        tick();
        check("andi_imm", D_IMM, 32'h0001FFFF);
        drive(enc_j(5'd17, 5'd0, 22'h200000), 32'h304);
        tick();
        check("j_imm", D_IMM, 32'hFFE00000);
        check("j_branch", D_BRANCH, 1);
        check("j_we", D_WE, 0);
        drive(enc_i(5'd11, 5'd10, 5'd9, 17'h00033), 32'h308);
        tick();
        check("lsri_imm", D_IMM, 32'h13);
        check("lsri_fwd_c", D_FWD_C, 0);
        drive(enc_i(5'd15, 5'd0, 5'd10, 17'h01006), 32'h30C);
        tick();
        check("br_imm", D_IMM, 32'h6);
        check("br_fwd_b", D_FWD_B, 1);
        check("br_we", D_WE, 0);
        drive(enc_i(5'd0, 5'd9, 5'd2, 17'h1FFFF), 32'h310);
        tick();
        check("addi_imm", D_IMM, 32'hFFFFFFFF);
        drive(enc_i(5'd21, 5'd9, 5'd2, 17'd8), 32'h314);
        tick();
        check("st_mem_wr", D_MEM_WR, 1);
        check("st_we", D_WE, 0);
        check("st_fwd_s", D_FWD_S, 1);
        check("st_fwd_b", D_FWD_B, 0);
        idle(3);

        // Back-pressure: bundle held for three cycles, then drain in order
        drive(enc_r(5'd4, 5'd11, 5'd1, 5'd2), 32'h400);
        tick();
        D_READY = 1'b0;
        drive(enc_i(5'd2, 5'd12, 5'd11, 17'd5), 32'h404);
        #1 check("bp_in_ready0", IN_READY, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_valid", D_VALID, 1);
            check("bp_hold_ra", D_RA, 11);
            check("bp_hold_pc", D_PC, 32'h400);
            check("bp_hold_in_ready", IN_READY, 0);
        end
        D_READY = 1'b1;
        #1 check("bp_release_in_ready", IN_READY, 1);
        tick();
        check("bp_ori_opcode", D_OPCODE, 2);
        check("bp_ori_fwd_b", D_FWD_B, 1);
        drive(enc_r(5'd10, 5'd13, 5'd12, 5'd11), 32'h408);
        tick();
        check("bp_xor_pc", D_PC, 32'h408);
        check("bp_xor_fwd_b", D_FWD_B, 1);
        check("bp_xor_fwd_c", D_FWD_C, 2);
        idle(3);

        // Flush during a load-use hazard
        drive(enc_i(5'd19, 5'd5, 5'd1, 17'd4), 32'h500);
        tick();
        drive(enc_r(5'd4, 5'd6, 5'd5, 5'd2), 32'h504);
        FLUSH = 1'b1;
        #1 check("fl_in_ready", IN_READY, 1);
        tick();
        check("fl_d_valid", D_VALID, 0);
        FLUSH = 1'b0;
        drive(enc_r(5'd4, 5'd7, 5'd5, 5'd5), 32'h600);
        #1 check("fl_after_in_ready", IN_READY, 1);
        tick();
        check("fl_after_valid", D_VALID, 1);
        check("fl_after_fwd_b", D_FWD_B, 0);
        check("fl_after_fwd_c", D_FWD_C, 0);
        idle(3);

        // Illegal opcode followed by ADD r1,r1,r1
        drive(enc_r(5'd25, 5'd1, 5'd1, 5'd1), 32'h700);
        tick();
        check("ill_flag", D_ILLEGAL, 1);
        check("ill_we", D_WE, 0);
        check("ill_fwd_b", D_FWD_B, 0);
        drive(enc_r(5'd4, 5'd1, 5'd1, 5'd1), 32'h704);
        tick();
        check("ill_add_flag", D_ILLEGAL, 0);
        check("ill_add_fwd_b", D_FWD_B, 0);
        check("ill_add_fwd_c", D_FWD_C, 0);

        // Asynchronous reset mid-operation
        drive(enc_r(5'd4, 5'd2, 5'd1, 5'd1), 32'h800);
        tick();
        check("ar_pre_valid", D_VALID, 1);
        IN_VALID = 1'b0;
        #3 RSTN = 1'b0;
        #1 check("ar_valid", D_VALID, 0);
        check("ar_ra", D_RA, 0);
        #2 RSTN = 1'b1;
        drive(enc_r(5'd5, 5'd3, 5'd2, 5'd2), 32'h804);
        tick();
        check("ar_first_valid", D_VALID, 1);
        check("ar_first_fwd_b", D_FWD_B, 0);
        check("ar_first_fwd_c", D_FWD_C, 0);
        IN_VALID = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
